// File: rtl/filter_pkg.sv
// Shared types for the two-pump filter controller: FSM state type and its external encoding.
package filter_pkg;

    localparam logic [2:0] STATE_IDLE      = 3'd0;
    localparam logic [2:0] STATE_FILL      = 3'd1;
    localparam logic [2:0] STATE_DRAIN_MIN = 3'd2;
    localparam logic [2:0] STATE_DRAIN_MAX = 3'd3;
    localparam logic [2:0] STATE_STOPPING  = 3'd4;
    localparam logic [2:0] STATE_FAULT     = 3'd5;

    typedef enum logic [2:0] {
        StIdle     = STATE_IDLE,
        StFill     = STATE_FILL,
        StDrainMin = STATE_DRAIN_MIN,
        StDrainMax = STATE_DRAIN_MAX,
        StStopping = STATE_STOPPING,
        StFault    = STATE_FAULT
    } state_t;

endpackage

// File: rtl/pwm_ramp.sv
// Duty register for one pump: drops to a lower target at once, climbs to a higher target by
// RAMP_STEP per tick without overshooting.
module pwm_ramp #(
    parameter int unsigned PWM_W     = 8,
    parameter int unsigned RAMP_STEP = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             tick,
    input  logic [PWM_W-1:0] target,
    output logic [PWM_W-1:0] duty
);

    localparam logic [PWM_W:0] STEP = (PWM_W + 1)'(RAMP_STEP);

    logic [PWM_W:0]   sum;
    logic [PWM_W-1:0] duty_d;

    always_comb begin
        // One extra bit so the step can never wrap past the target.
        sum    = {1'b0, duty} + STEP;
        duty_d = duty;
        if (target < duty) begin
            duty_d = target;
        end else if (target > duty && tick) begin
            duty_d = (sum > {1'b0, target}) ? target : sum[PWM_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            duty <= '0;
        end else begin
            duty <= duty_d;
        end
    end

endmodule

// File: rtl/filter_ctrl.sv
// Fill/drain pump sequencer with slew-limited duty, stop timeout and latched fault.
// Define FILTER_DEBOUNCE_EN to synchronise and debounce is_empty before the FSM uses it.
module filter_ctrl
    import filter_pkg::*;
#(
    parameter int unsigned     STATUS_W            = 4,
    parameter int unsigned     PWM_W               = 8,
    parameter int unsigned     PWM_MAX             = 230,
    parameter int unsigned     PWM_MIN             = 77,
    parameter longint unsigned FILL_CYCLES         = 64'd6_000_000_000,
    parameter longint unsigned MIN_CYCLES          = 64'd250_000_000,
    parameter longint unsigned STOP_TIMEOUT_CYCLES = 64'd500_000_000,
    parameter int unsigned     RAMP_STEP           = 8,
    parameter int unsigned     RAMP_DIV            = 50_000,
    parameter longint unsigned DEBOUNCE_CYCLES     = 64'd1_000_000
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                enable,
    input  logic [STATUS_W-1:0] status_data,
    input  logic [STATUS_W-1:0] status_mask,
    input  logic                is_empty,
    input  logic                fault_clr,
    output logic [PWM_W-1:0]    pwm_duty_a,
    output logic [PWM_W-1:0]    pwm_duty_b,
    output logic [2:0]          state_o,
    output logic                fault
);

    if (PWM_MIN >= PWM_MAX || RAMP_STEP < 1 || RAMP_DIV < 1 || DEBOUNCE_CYCLES < 1) begin : g_bad_cfg
        $error("filter_ctrl: invalid parameter set");
    end

    localparam longint unsigned MAX_FM  = (FILL_CYCLES > MIN_CYCLES) ? FILL_CYCLES : MIN_CYCLES;
    localparam longint unsigned MAX_CYC =
        (MAX_FM > STOP_TIMEOUT_CYCLES) ? MAX_FM : STOP_TIMEOUT_CYCLES;
    localparam int unsigned TW = $clog2(MAX_CYC + 1);
    localparam int unsigned PW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

    localparam logic [TW-1:0]    FILL_EXP = TW'(FILL_CYCLES - 1);
    localparam logic [TW-1:0]    MIN_EXP  = TW'(MIN_CYCLES - 1);
    localparam logic [TW-1:0]    STOP_EXP = TW'(STOP_TIMEOUT_CYCLES - 1);
    localparam logic [PWM_W-1:0] PWM_HI   = PWM_W'(PWM_MAX);
    localparam logic [PWM_W-1:0] PWM_LO   = PWM_W'(PWM_MIN);

    state_t           state_q, state_d;
    logic [TW-1:0]    timer_q;
    logic [PW-1:0]    presc_q;
    logic             fault_q;
    logic             tick;
    logic             critical;
    logic             empty_lvl;
    logic [PWM_W-1:0] target_a, target_b;

    assign critical = |(status_data & status_mask);

`ifdef FILTER_DEBOUNCE_EN
    localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync_q1, sync_q2, deb_q;
    logic [DW-1:0] deb_cnt_q;

    // Counter runs only while the synchronised input disagrees with the debounced level.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q1   <= 1'b0;
            sync_q2   <= 1'b0;
            deb_q     <= 1'b0;
            deb_cnt_q <= '0;
        end else begin
            sync_q1 <= is_empty;
            sync_q2 <= sync_q1;
            if (sync_q2 == deb_q) begin
                deb_cnt_q <= '0;
            end else if (deb_cnt_q == DW'(DEBOUNCE_CYCLES - 1)) begin
                deb_q     <= sync_q2;
                deb_cnt_q <= '0;
            end else begin
                deb_cnt_q <= deb_cnt_q + DW'(1);
            end
        end
    end

    assign empty_lvl = deb_q;
`else
    assign empty_lvl = is_empty;
`endif

    assign tick = (presc_q == PW'(RAMP_DIV - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc_q <= '0;
        end else begin
            presc_q <= tick ? '0 : presc_q + PW'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:     if (enable && critical) state_d = StFill;
            StFill: begin
                if (!enable)                    state_d = StStopping;
                else if (timer_q == FILL_EXP)   state_d = StDrainMin;
            end
            StDrainMin: begin
                if (!enable || !critical)       state_d = StStopping;
                else if (empty_lvl)             state_d = StFill;
                else if (timer_q == MIN_EXP)    state_d = StDrainMax;
            end
            StDrainMax: begin
                if (!enable || !critical)       state_d = StStopping;
                else if (empty_lvl)             state_d = StFill;
            end
            StStopping: begin
                if (empty_lvl)                  state_d = StIdle;
                else if (timer_q == STOP_EXP)   state_d = StFault;
            end
            StFault:    if (fault_clr) state_d = StIdle;
            default:    state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            timer_q <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_d != state_q) begin
                timer_q <= '0;
            end else if (timer_q != '1) begin
                timer_q <= timer_q + TW'(1);
            end
            fault_q <= (state_d == StFault);
        end
    end

    always_comb begin
        target_a = '0;
        target_b = '0;
        case (state_q)
            StFill:                 target_a = PWM_HI;
            StDrainMin:             target_b = PWM_LO;
            StDrainMax, StStopping: target_b = PWM_HI;
            default: ;
        endcase
    end

    pwm_ramp #(
        .PWM_W    (PWM_W),
        .RAMP_STEP(RAMP_STEP)
    ) u_ramp_a (
        .clk    (clk),
        .reset_n(reset_n),
        .tick   (tick),
        .target (target_a),
        .duty   (pwm_duty_a)
    );

    pwm_ramp #(
        .PWM_W    (PWM_W),
        .RAMP_STEP(RAMP_STEP)
    ) u_ramp_b (
        .clk    (clk),
        .reset_n(reset_n),
        .tick   (tick),
        .target (target_b),
        .duty   (pwm_duty_b)
    );

    assign state_o = state_q;
    assign fault   = fault_q;

endmodule
